// File: rtl/dnn_weight_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_pkg
// Description : Shared geometry, types and layer arithmetic for the weight streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

  localparam int BitSize      = 8;
  localparam int M_W_BitSize  = 16;
  localparam int MaxNumNerves = 6;
  localparam int NumLayers    = 4;
  localparam int ImageSize    = 16;
  localparam int LNN [NumLayers-1:0] = '{2, 3, 5, 6};

  typedef logic [MaxNumNerves-1:0][M_W_BitSize-1:0] weight_row_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESET  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ws_state_t;

  function automatic int layer_words(input int k);
    int w;
    w = ImageSize;
    for (int i = 0; i < NumLayers; i++) begin
      if (k > 0 && i == NumLayers - k) w = LNN[i];
    end
    return w;
  endfunction

  // Layer 0 sees the whole bus; deeper layers drive as many lanes as they have rows.
  function automatic int layer_lanes(input int k);
    return (k == 0) ? MaxNumNerves : layer_words(k);
  endfunction

  function automatic int layer_base(input int k);
    int b;
    b = 0;
    for (int i = 0; i < NumLayers; i++) begin
      if (i < k) b = b + layer_words(i);
    end
    return b;
  endfunction

  function automatic int total_words();
    return layer_base(NumLayers);
  endfunction

  function automatic weight_row_t lane_mask(input int k);
    weight_row_t m;
    m = '0;
    for (int i = 0; i < MaxNumNerves; i++) begin
      if (i >= MaxNumNerves - layer_lanes(k)) m[i] = '1;
    end
    return m;
  endfunction

  localparam int TotalWords = total_words();
  localparam int AddrW      = $clog2(TotalWords);
  localparam int LayerW     = (NumLayers > 1) ? $clog2(NumLayers) : 1;

endpackage
`default_nettype wire

// File: rtl/dnn_weight_streamer_ram.sv
`default_nettype none
// ============================================================================
// Module      : dnn_weight_ram
// Description : 1W1R weight row store, one row per address, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_weight_ram
  import dnn_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  weight_row_t      wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output weight_row_t      rd_data_o
);

  weight_row_t mem_q [TotalWords];
  weight_row_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dnn_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module      : dnn_weight_streamer
// Description : Pulses the DNN reset, then streams the preloaded weight rows.
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_weight_streamer
  import dnn_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              in_wr_en,
  input  logic [AddrW-1:0]  in_wr_addr,
  input  weight_row_t       in_wr_data,
  input  logic              in_start,
  output logic              out_dnn_res_n,
  output weight_row_t       out_weights,
  output logic [LayerW-1:0] out_layer,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_wr_err
);

  localparam logic [AddrW-1:0] c_LAST_ROW = AddrW'(TotalWords - 1);

  ws_state_t         state_q, state_d;
  logic [AddrW-1:0]  row_q, row_d;
  logic [LayerW-1:0] layer_q, layer_d;
  logic              ran_q, ran_d;

  logic              res_n_q, res_n_d;
  weight_row_t       weights_q, weights_d;
  logic [LayerW-1:0] layer_out_q, layer_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;

  logic              w_busy;
  logic              w_wr_ok;
  logic [AddrW-1:0]  w_rd_addr;
  weight_row_t       w_rd_data;
  weight_row_t       w_mask      [NumLayers];
  logic [AddrW-1:0]  w_layer_end [NumLayers];

  for (genvar l = 0; l < NumLayers; l++) begin : g_layer
    assign w_mask[l]      = lane_mask(l);
    assign w_layer_end[l] = AddrW'(layer_base(l + 1) - 1);
  end

  assign w_busy  = (state_q == RESET) || (state_q == STREAM);
  assign w_wr_ok = in_wr_en && !w_busy &&
                   ({1'b0, in_wr_addr} < (AddrW + 1)'(TotalWords));

  dnn_weight_ram u_ram (
    .clk       (clk),
    .wr_en_i   (w_wr_ok),
    .wr_addr_i (in_wr_addr),
    .wr_data_i (in_wr_data),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_rd_data)
  );

  // Read address runs one row ahead of the row being presented.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    layer_d     = layer_q;
    ran_d       = ran_q;
    w_rd_addr   = '0;
    res_n_d     = 1'b1;
    weights_d   = '0;
    layer_out_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    wr_err_d    = wr_err_q | (w_busy & (in_wr_en | in_start));
    case (state_q)
      IDLE: begin
        res_n_d = ran_q;
        if (in_start) state_d = RESET;
      end
      RESET: begin
        res_n_d = 1'b0;
        busy_d  = 1'b1;
        row_d   = '0;
        layer_d = '0;
        state_d = STREAM;
      end
      STREAM: begin
        busy_d      = 1'b1;
        ran_d       = 1'b1;
        weights_d   = w_rd_data & w_mask[layer_q];
        layer_out_d = layer_q;
        if (row_q == c_LAST_ROW) begin
          w_rd_addr = row_q;
          state_d   = DONE;
        end else begin
          row_d     = row_q + AddrW'(1);
          w_rd_addr = row_q + AddrW'(1);
          if (row_q == w_layer_end[layer_q]) layer_d = layer_q + LayerW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      row_q       <= '0;
      layer_q     <= '0;
      ran_q       <= 1'b0;
      res_n_q     <= 1'b0;
      weights_q   <= '0;
      layer_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      layer_q     <= layer_d;
      ran_q       <= ran_d;
      res_n_q     <= res_n_d;
      weights_q   <= weights_d;
      layer_out_q <= layer_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign out_dnn_res_n = res_n_q;
  assign out_weights   = weights_q;
  assign out_layer     = layer_out_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_wr_err    = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dnn_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dnn_weight_streamer
// Description : Directed bench with a transaction-level reference model of the stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dnn_weight_streamer;
  import dnn_pkg::*;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic              in_wr_en = 1'b0;
  logic [AddrW-1:0]  in_wr_addr = '0;
  weight_row_t       in_wr_data = '0;
  logic              in_start = 1'b0;
  logic              out_dnn_res_n;
  weight_row_t       out_weights;
  logic [LayerW-1:0] out_layer;
  logic              out_busy;
  logic              out_done;
  logic              out_wr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dnn_weight_streamer dut (
    .clk           (clk),
    .res           (res),
    .in_wr_en      (in_wr_en),
    .in_wr_addr    (in_wr_addr),
    .in_wr_data    (in_wr_data),
    .in_start      (in_start),
    .out_dnn_res_n (out_dnn_res_n),
    .out_weights   (out_weights),
    .out_layer     (out_layer),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_wr_err    (out_wr_err)
  );

  typedef struct packed {
    logic              res_n;
    weight_row_t       w;
    logic [LayerW-1:0] layer;
    logic              busy;
    logic              done;
  } exp_t;

  // Rows per layer for the default configuration: image, then 2, 3, 5 nerves.
  int          m_words [4] = '{16, 2, 3, 5};
  weight_row_t m_store [32];
  exp_t        q_exp [$];
  exp_t        cur = '0;
  exp_t        e_tmp;
  logic        ran_m = 1'b0;
  logic        err_m = 1'b0;
  int          m_len;

  function automatic exp_t row_e(input int r);
    exp_t e;
    int   l;
    int   base;
    int   lanes;
    l = 0;
    base = 0;
    while (r >= base + m_words[l]) begin
      base = base + m_words[l];
      l++;
    end
    lanes   = (l == 0) ? 6 : m_words[l];
    e       = '0;
    e.res_n = 1'b1;
    e.busy  = 1'b1;
    e.layer = LayerW'(l);
    for (int i = 0; i < 6; i++) begin
      if (i >= 6 - lanes) e.w[i] = m_store[r][i];
    end
    return e;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      q_exp.delete();
      ran_m = 1'b0;
      err_m = 1'b0;
      cur   = '0;
    end else begin
      m_len = q_exp.size();
      if (m_len > 0) begin
        cur = q_exp.pop_front();
      end else begin
        cur       = '0;
        cur.res_n = ran_m;
      end
      if (cur.done) ran_m = 1'b1;
      if (m_len >= 2 && (in_wr_en || in_start)) err_m = 1'b1;
      if (m_len < 2 && in_wr_en && in_wr_addr < 26) m_store[in_wr_addr] = in_wr_data;
      if (m_len == 0 && in_start) begin
        e_tmp      = '0;
        e_tmp.busy = 1'b1;
        q_exp.push_back(e_tmp);
        for (int r = 0; r < 26; r++) q_exp.push_back(row_e(r));
        e_tmp       = '0;
        e_tmp.res_n = 1'b1;
        e_tmp.done  = 1'b1;
        q_exp.push_back(e_tmp);
      end
    end
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("res_n",   96'(out_dnn_res_n), 96'(cur.res_n));
    chk("weights", out_weights,        cur.w);
    chk("layer",   96'(out_layer),     96'(cur.layer));
    chk("busy",    96'(out_busy),      96'(cur.busy));
    chk("done",    96'(out_done),      96'(cur.done));
    chk("wr_err",  96'(out_wr_err),    96'(err_m));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input weight_row_t d);
    in_wr_en   = 1'b1;
    in_wr_addr = AddrW'(a);
    in_wr_data = d;
    tick();
    in_wr_en   = 1'b0;
  endtask

  // Observe 30 cycles after a start sampled on the previous edge; n = edges since start.
  task automatic watch_first_stream();
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      case (n)
        0:  chk("pin_idle_busy", 96'(out_busy), 96'd0);
        1:  begin
              chk("pin_rst_pulse", 96'(out_dnn_res_n), 96'd0);
              chk("pin_rst_busy",  96'(out_busy),      96'd1);
            end
        2:  chk("pin_row0_res_n", 96'(out_dnn_res_n), 96'd1);
        7:  chk("pin_row5", out_weights, 96'h0005_0005_0005_0005_0005_0005);
        17: chk("pin_row15_layer", 96'(out_layer), 96'd0);
        18: begin
              chk("pin_row16", out_weights, 96'h0010_0010_0000_0000_0000_0000);
              chk("pin_row16_layer", 96'(out_layer), 96'd1);
            end
        20: begin
              chk("pin_row18", out_weights, 96'h0012_0012_0012_0000_0000_0000);
              chk("pin_row18_layer", 96'(out_layer), 96'd2);
            end
        23: begin
              chk("pin_row21", out_weights, 96'h0015_0015_0015_0015_0015_0000);
              chk("pin_row21_layer", 96'(out_layer), 96'd3);
            end
        27: chk("pin_row25_done", 96'(out_done), 96'd0);
        28: begin
              chk("pin_done", 96'(out_done), 96'd1);
              chk("pin_done_busy", 96'(out_busy), 96'd0);
            end
        29: chk("pin_idle_res_n", 96'(out_dnn_res_n), 96'd1);
        default: ;
      endcase
    end
    tick();
  endtask

  task automatic watch_row0(input logic [95:0] row0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 2)  chk("pin_new_row0", out_weights, row0);
      if (n == 28) chk("pin_new_done", 96'(out_done), 96'd1);
    end
    tick();
  endtask

  int lows;
  int dones;

  initial begin
    repeat (2) tick();
    chk("pin_reset_res_n", 96'(out_dnn_res_n), 96'd0);
    chk("pin_reset_weights", out_weights, 96'd0);
    res = 1'b0;
    tick();

    for (int a = 0; a < 26; a++) wr(a, {6{16'(a)}});
    wr(26, '1);
    wr(31, '1);

    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    watch_first_stream();

    in_wr_en   = 1'b1;
    in_wr_addr = '0;
    in_wr_data = {6{16'hA5A5}};
    in_start   = 1'b1;
    tick();
    in_wr_en = 1'b0;
    in_start = 1'b0;
    watch_row0({6{16'hA5A5}});

    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    tick();
    in_start   = 1'b1;
    in_wr_en   = 1'b1;
    in_wr_addr = AddrW'(3);
    in_wr_data = '1;
    tick();
    in_start = 1'b0;
    in_wr_en = 1'b0;
    repeat (30) tick();
    chk("pin_wr_err", 96'(out_wr_err), 96'd1);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    repeat (32) tick();

    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    repeat (12) tick();
    res = 1'b1;
    #1;
    chk("pin_abort_busy",   96'(out_busy),      96'd0);
    chk("pin_abort_weight", out_weights,        96'd0);
    chk("pin_abort_res_n",  96'(out_dnn_res_n), 96'd0);
    chk("pin_abort_err",    96'(out_wr_err),    96'd0);
    tick();
    res = 1'b0;
    repeat (30) tick();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    watch_row0({6{16'hA5A5}});

    lows  = 0;
    dones = 0;
    in_start = 1'b1;
    for (int i = 0; i < 65; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_dnn_res_n) lows++;
      if (out_done) dones++;
    end
    in_start = 1'b0;
    chk("pin_b2b_resets", 96'(lows),  96'd3);
    chk("pin_b2b_dones",  96'(dones), 96'd2);
    repeat (35) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
